// File: rtl/arp_cache_ctrl_pkg.sv
// arp_cache_ctrl_pkg: shared constants and the one-hot lookup FSM encoding
// used by the ARP cache controller.
package arp_cache_ctrl_pkg;

    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'b0001,
        ST_LOOKUP     = 4'b0010,
        ST_SEND_REQ   = 4'b0100,
        ST_WAIT_REPLY = 4'b1000
    } state_e;

endpackage

// File: rtl/arp_cache_ctrl_cache.sv
// arp_cache_ctrl_cache: small IP->MAC store with parallel match, in-place overwrite
// of known IPs and round-robin replacement for new ones.
module arp_cache_ctrl_cache #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [31:0] wr_ip,
    input  logic [47:0] wr_mac,
    input  logic [31:0] rd_ip,
    output logic        rd_hit,
    output logic [47:0] rd_mac
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [31:0]      ip_q  [DEPTH];
    logic [31:0]      ip_d  [DEPTH];
    logic [47:0]      mac_q [DEPTH];
    logic [47:0]      mac_d [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [DEPTH-1:0] wr_match, rd_match;

    always_comb begin
        rd_mac = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_match[i] = vld_q[i] && ip_q[i] == wr_ip;
            rd_match[i] = vld_q[i] && ip_q[i] == rd_ip;
            rd_mac      = rd_mac | (rd_match[i] ? mac_q[i] : 48'h0);
        end
        rd_hit = |rd_match;
    end

    // IPs are unique in the store, so an overwrite never consumes a new slot
    always_comb begin
        vld_d = vld_q;
        ip_d  = ip_q;
        mac_d = mac_q;
        ptr_d = ptr_q;
        if (wr_en && |wr_match) begin
            for (int i = 0; i < DEPTH; i++)
                if (wr_match[i]) mac_d[i] = wr_mac;
        end else if (wr_en) begin
            vld_d[ptr_q] = 1'b1;
            ip_d[ptr_q]  = wr_ip;
            mac_d[ptr_q] = wr_mac;
            ptr_d        = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ip_q[i]  <= '0;
                mac_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            ptr_q <= ptr_d;
            ip_q  <= ip_d;
            mac_q <= mac_d;
        end
    end

endmodule

// File: rtl/arp_cache_ctrl.sv
// arp_cache_ctrl: learns IP->MAC pairs from received ARP, answers requests, and
// resolves destination MACs for the TX path with timed ARP request retries.
module arp_cache_ctrl
    import arp_cache_ctrl_pkg::*;
#(
    parameter int CACHE_DEPTH = 4,
    parameter int TIMEOUT_CYC = 12_500_000,
    parameter int MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    input  logic [47:0] src_mac,
    input  logic [31:0] src_ip,
    input  logic        lkp_req,
    input  logic [31:0] lkp_ip,
    output logic        lkp_busy,
    output logic        lkp_done,
    output logic        lkp_hit,
    output logic [47:0] lkp_mac,
    output logic        arp_tx_en,
    output logic        arp_tx_type,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    input  logic        tx_done
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    state_e        state_q, state_d;
    logic [31:0]   lkp_ip_q, lkp_ip_d;
    logic          chit_q, chit_d;
    logic [47:0]   cmac_q, cmac_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          sent_q, sent_d;
    logic          done_q, done_d;
    logic          hit_q, hit_d;
    logic [47:0]   mac_q, mac_d;
    logic          reply_pend_q, tx_busy_q, tx_type_q;
    logic [47:0]   rmac_q, tx_mac_q;
    logic [31:0]   rip_q, tx_ip_q;
    logic          rd_hit;
    logic [47:0]   rd_mac;
    logic          rx_req, grant_reply, grant_req, bypass, counting, timeout, reply_match;

    arp_cache_ctrl_cache #(.DEPTH(CACHE_DEPTH)) u_cache (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (arp_rx_done && src_ip != 32'h0),
        .wr_ip  (src_ip),
        .wr_mac (src_mac),
        .rd_ip  (lkp_ip),
        .rd_hit (rd_hit),
        .rd_mac (rd_mac)
    );

    // A request arriving this cycle holds off our own ARP request so the reply goes first
    assign rx_req      = arp_rx_done && !arp_rx_type;
    assign grant_reply = !tx_busy_q && reply_pend_q;
    assign grant_req   = !tx_busy_q && !reply_pend_q && !rx_req && state_q == ST_SEND_REQ;
    assign arp_tx_en   = grant_reply || grant_req;
    assign arp_tx_type = arp_tx_en ? grant_reply : tx_type_q;
    assign des_mac     = arp_tx_en ? (grant_reply ? rmac_q : BCAST_MAC) : tx_mac_q;
    assign des_ip      = arp_tx_en ? (grant_reply ? rip_q : lkp_ip_q) : tx_ip_q;

    assign bypass      = arp_rx_done && src_ip == lkp_ip;
    assign counting    = sent_q || tx_done;
    assign timeout     = counting && timer_q == TW'(TIMEOUT_CYC - 1);
    assign reply_match = arp_rx_done && arp_rx_type && src_ip == lkp_ip_q;

    assign lkp_busy = state_q != ST_IDLE;
    assign lkp_done = done_q;
    assign lkp_hit  = hit_q;
    assign lkp_mac  = mac_q;

    always_comb begin
        state_d  = state_q;
        lkp_ip_d = lkp_ip_q;
        chit_d   = chit_q;
        cmac_d   = cmac_q;
        retry_d  = retry_q;
        timer_d  = timer_q;
        sent_d   = sent_q;
        done_d   = 1'b0;
        hit_d    = hit_q;
        mac_d    = mac_q;
        case (state_q)
            ST_IDLE: if (lkp_req) begin
                state_d  = ST_LOOKUP;
                lkp_ip_d = lkp_ip;
                chit_d   = bypass || rd_hit;
                cmac_d   = bypass ? src_mac : rd_mac;
            end
            ST_LOOKUP: begin
                state_d = chit_q ? ST_IDLE : ST_SEND_REQ;
                done_d  = chit_q;
                hit_d   = chit_q ? 1'b1 : hit_q;
                mac_d   = chit_q ? cmac_q : mac_q;
                retry_d = '0;
            end
            ST_SEND_REQ: if (grant_req) begin
                state_d = ST_WAIT_REPLY;
                timer_d = '0;
                sent_d  = 1'b0;
            end
            ST_WAIT_REPLY: begin
                timer_d = counting ? timer_q + 1'b1 : timer_q;
                sent_d  = sent_q || tx_done;
                if (reply_match) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    hit_d   = 1'b1;
                    mac_d   = src_mac;
                end else if (timeout && retry_q == RW'(MAX_RETRY - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    hit_d   = 1'b0;
                    mac_d   = '0;
                end else if (timeout) begin
                    state_d = ST_SEND_REQ;
                    retry_d = retry_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            lkp_ip_q <= '0;
            chit_q   <= 1'b0;
            cmac_q   <= '0;
            retry_q  <= '0;
            timer_q  <= '0;
            sent_q   <= 1'b0;
            done_q   <= 1'b0;
            hit_q    <= 1'b0;
            mac_q    <= '0;
        end else begin
            state_q  <= state_d;
            lkp_ip_q <= lkp_ip_d;
            chit_q   <= chit_d;
            cmac_q   <= cmac_d;
            retry_q  <= retry_d;
            timer_q  <= timer_d;
            sent_q   <= sent_d;
            done_q   <= done_d;
            hit_q    <= hit_d;
            mac_q    <= mac_d;
        end
    end

    // A newer request sets the pending flag even in the cycle the older reply is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reply_pend_q <= 1'b0;
            rip_q        <= '0;
            rmac_q       <= '0;
            tx_busy_q    <= 1'b0;
            tx_type_q    <= 1'b0;
            tx_mac_q     <= '0;
            tx_ip_q      <= '0;
        end else begin
            reply_pend_q <= rx_req || (reply_pend_q && !grant_reply);
            if (rx_req) begin
                rip_q  <= src_ip;
                rmac_q <= src_mac;
            end
            tx_busy_q <= arp_tx_en || (tx_busy_q && !tx_done);
            if (arp_tx_en) begin
                tx_type_q <= arp_tx_type;
                tx_mac_q  <= des_mac;
                tx_ip_q   <= des_ip;
            end
        end
    end

endmodule

// File: tb/tb_arp_cache_ctrl.sv
// tb_arp_cache_ctrl: directed and randomized checks of arp_cache_ctrl against a
// transaction-level model of the cache (oldest-first eviction queue).
module tb_arp_cache_ctrl;

    localparam int DEPTH = 4;
    localparam int TO    = 100;
    localparam int RETRY = 3;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        arp_rx_done = 1'b0, arp_rx_type = 1'b0, lkp_req = 1'b0, tx_done = 1'b0;
    logic [47:0] src_mac = '0;
    logic [31:0] src_ip = '0, lkp_ip = '0;
    logic        lkp_busy, lkp_done, lkp_hit, arp_tx_en, arp_tx_type;
    logic [47:0] lkp_mac, des_mac;
    logic [31:0] des_ip;

    always #4 clk = ~clk;

    arp_cache_ctrl #(.CACHE_DEPTH(DEPTH), .TIMEOUT_CYC(TO), .MAX_RETRY(RETRY)) dut (
        .clk(clk), .rst_n(rst_n), .arp_rx_done(arp_rx_done), .arp_rx_type(arp_rx_type),
        .src_mac(src_mac), .src_ip(src_ip), .lkp_req(lkp_req), .lkp_ip(lkp_ip),
        .lkp_busy(lkp_busy), .lkp_done(lkp_done), .lkp_hit(lkp_hit), .lkp_mac(lkp_mac),
        .arp_tx_en(arp_tx_en), .arp_tx_type(arp_tx_type), .des_mac(des_mac), .des_ip(des_ip),
        .tx_done(tx_done)
    );

    int n_chk = 0, n_fail = 0;

    typedef struct { logic [31:0] ip; logic [47:0] mac; } ent_t;
    ent_t cache_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_learn(input logic [31:0] ip, input logic [47:0] mac);
        if (ip == 32'h0) return;
        foreach (cache_q[i])
            if (cache_q[i].ip == ip) begin
                cache_q[i].mac = mac;
                return;
            end
        if (cache_q.size() == DEPTH) void'(cache_q.pop_front());
        cache_q.push_back('{ip, mac});
    endfunction

    function automatic bit m_find(input logic [31:0] ip, output logic [47:0] mac);
        mac = '0;
        foreach (cache_q[i])
            if (cache_q[i].ip == ip) begin
                mac = cache_q[i].mac;
                return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic tx_finish(input logic [31:0] ip, input int d);
        repeat (d) begin
            tick();
            check("tx_busy_no_en", arp_tx_en, 0);
            check("tx_held_ip", des_ip, ip);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic rx(input bit typ, input logic [47:0] mac, input logic [31:0] ip);
        arp_rx_done = 1'b1; arp_rx_type = typ; src_mac = mac; src_ip = ip;
        tick();
        arp_rx_done = 1'b0;
        m_learn(ip, mac);
        if (!typ) begin
            check("rply_en", arp_tx_en, 1);
            check("rply_type", arp_tx_type, 1);
            check("rply_dip", des_ip, ip);
            check("rply_dmac", des_mac, mac);
            tx_finish(ip, $urandom_range(1, 4));
        end
    endtask

    // n_to: attempts that time out before a reply is injected (>= RETRY means never)
    task automatic lookup(input logic [31:0] ip, input int n_to);
        logic [47:0] emac, rmac;
        bit ehit;
        int n;
        ehit = m_find(ip, emac);
        lkp_req = 1'b1; lkp_ip = ip;
        tick();
        lkp_req = 1'b0;
        check("lkp_busy", lkp_busy, 1);
        check("lkp_early", lkp_done, 0);
        tick();
        if (ehit) begin
            check("hit_done", lkp_done, 1);
            check("hit_flag", lkp_hit, 1);
            check("hit_mac", lkp_mac, emac);
            check("hit_no_tx", arp_tx_en, 0);
        end else begin
            check("miss_no_done", lkp_done, 0);
            for (int a = 0; a < RETRY; a++) begin
                n = 0;
                while (!arp_tx_en && n < 8) begin tick(); n++; end
                check("req_en", arp_tx_en, 1);
                check("req_type", arp_tx_type, 0);
                check("req_dmac", des_mac, BCAST);
                check("req_dip", des_ip, ip);
                tx_finish(ip, $urandom_range(1, 4));
                if (a == n_to) begin
                    lkp_req = 1'b1; lkp_ip = ip ^ 32'h1;
                    tick();
                    lkp_req = 1'b0;
                    check("busy_ignore", lkp_done, 0);
                    repeat ($urandom_range(0, TO / 2)) begin
                        tick();
                        check("wait_quiet", lkp_done, 0);
                    end
                    rmac = {16'($urandom), 32'($urandom)};
                    rx(1'b1, rmac, ip);
                    check("rep_done", lkp_done, 1);
                    check("rep_hit", lkp_hit, 1);
                    check("rep_mac", lkp_mac, rmac);
                    tick();
                    check("done_pulse", lkp_done, 0);
                    check("hit_held", lkp_hit, 1);
                    return;
                end
                n = 1;
                while (!arp_tx_en && !lkp_done && n < 2 * TO) begin tick(); n++; end
                check("timeout_cycles", 64'(n), TO);
            end
            check("fail_done", lkp_done, 1);
            check("fail_hit", lkp_hit, 0);
            check("fail_mac", lkp_mac, 0);
            check("fail_no_tx", arp_tx_en, 0);
        end
        tick();
        check("done_pulse", lkp_done, 0);
    endtask

    task automatic do_reset();
        arp_rx_done = 1'b0; lkp_req = 1'b0; tx_done = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        check("rst_done", lkp_done, 0);
        check("rst_busy", lkp_busy, 0);
        check("rst_hit", lkp_hit, 0);
        check("rst_mac", lkp_mac, 0);
        check("rst_tx_en", arp_tx_en, 0);
        check("rst_tx_type", arp_tx_type, 0);
        check("rst_dmac", des_mac, 0);
        check("rst_dip", des_ip, 0);
        rst_n = 1'b1;
        cache_q.delete();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rip;
        logic [47:0] rm;
        int seen;
        do_reset();
        rx(1'b0, 48'hE04F_43E6_5C0B, 32'hC0A8_0166);
        lookup(32'hC0A8_0166, 0);
        lookup(32'hC0A8_0132, 0);
        lookup(32'hC0A8_0163, RETRY);
        lkp_req = 1'b1; lkp_ip = 32'hC0A8_0140;
        arp_rx_done = 1'b1; arp_rx_type = 1'b1; src_ip = 32'hC0A8_0140; src_mac = 48'h0011_2233_4455;
        tick();
        lkp_req = 1'b0; arp_rx_done = 1'b0;
        m_learn(32'hC0A8_0140, 48'h0011_2233_4455);
        tick();
        check("bypass_done", lkp_done, 1);
        check("bypass_hit", lkp_hit, 1);
        check("bypass_mac", lkp_mac, 48'h0011_2233_4455);
        tick();

        do_reset();
        for (int i = 1; i <= 5; i++) rx(1'b1, 48'hA000_0000_0000 + 48'(i), 32'h0A00_0000 + 32'(i));
        lookup(32'h0A00_0001, 0);
        rx(1'b1, 48'hBEEF_0000_0003, 32'h0A00_0003);
        rx(1'b1, 48'hA000_0000_0006, 32'h0A00_0006);
        lookup(32'h0A00_0004, 0);
        lookup(32'h0A00_0003, 0);
        lookup(32'h0A00_0006, 0);

        do_reset();
        lkp_req = 1'b1; lkp_ip = 32'hC0A8_0177;
        tick();
        lkp_req = 1'b0;
        tick();
        arp_rx_done = 1'b1; arp_rx_type = 1'b0; src_ip = 32'hC0A8_0105; src_mac = 48'h1234_5678_9ABC;
        #1;
        check("coll_req_held", arp_tx_en, 0);
        tick();
        arp_rx_done = 1'b0;
        m_learn(32'hC0A8_0105, 48'h1234_5678_9ABC);
        check("coll_rply_en", arp_tx_en, 1);
        check("coll_rply_type", arp_tx_type, 1);
        check("coll_rply_dip", des_ip, 32'hC0A8_0105);
        check("coll_rply_dmac", des_mac, 48'h1234_5678_9ABC);
        tx_finish(32'hC0A8_0105, 3);
        check("coll_req_en", arp_tx_en, 1);
        check("coll_req_type", arp_tx_type, 0);
        check("coll_req_dip", des_ip, 32'hC0A8_0177);
        tx_finish(32'hC0A8_0177, 2);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("arst_busy", lkp_busy, 0);
        check("arst_tx_en", arp_tx_en, 0);
        tick(); tick();
        rst_n = 1'b1;
        cache_q.delete();
        seen = 0;
        repeat (3 * TO) begin
            tick();
            seen += int'(lkp_done) + int'(arp_tx_en);
        end
        check("post_rst_quiet", 64'(seen), 0);
        lookup(32'hC0A8_0105, 0);

        for (int it = 0; it < 40; it++) begin
            rip = 32'hC0A8_0100 + 32'($urandom_range(1, 6));
            rm  = {16'($urandom), 32'($urandom)};
            case ($urandom_range(0, 3))
                0: rx(1'b0, rm, ($urandom_range(0, 7) == 0) ? 32'h0 : rip);
                1: rx(1'b1, rm, rip);
                default: lookup(rip, ($urandom_range(0, 5) == 0) ? RETRY : int'($urandom_range(0, 1)));
            endcase
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
